// File: rtl/arp_cache_ctrl.sv
// Multi-entry ARP cache: sequential lookup scan, parallel update with LRU-by-age
// replacement, per-entry aging, and ARP request generation with timed retries.

module arp_cache_entry #(
  parameter int P_TIMEOUT_TICKS = 300,
  parameter int AW              = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_tick,
  input  logic          i_we,
  input  logic [31:0]   i_ip,
  input  logic [47:0]   i_mac,
  output logic          o_vld,
  output logic [31:0]   o_ip,
  output logic [47:0]   o_mac,
  output logic [AW-1:0] o_age
);
  // Flush beats a write; a write beats an aging tick/timeout in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vld <= 1'b0;
      o_ip  <= '0;
      o_mac <= '0;
      o_age <= '0;
    end else if (i_flush) begin
      o_vld <= 1'b0;
      o_age <= '0;
    end else if (i_we) begin
      o_vld <= 1'b1;
      o_ip  <= i_ip;
      o_mac <= i_mac;
      o_age <= '0;
    end else if (i_tick && o_vld) begin
      if (o_age == AW'(P_TIMEOUT_TICKS - 1)) begin
        o_vld <= 1'b0;
        o_age <= '0;
      end else begin
        o_age <= o_age + 1'b1;
      end
    end
  end
endmodule

module arp_cache_ctrl #(
  parameter int P_DEPTH         = 8,
  parameter int P_TIMEOUT_TICKS = 300,
  parameter int P_RETRY_TICKS   = 1,
  parameter int P_MAX_RETRY     = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_flush,
  input  logic [31:0] i_seek_ip,
  input  logic        i_seek_valid,
  output logic        o_seek_ready,
  output logic        o_seek_done,
  output logic        o_seek_hit,
  output logic [47:0] o_seek_mac,
  input  logic [31:0] i_updata_ip,
  input  logic [47:0] i_updata_mac,
  input  logic        i_updata_valid,
  output logic [31:0] o_req_ip,
  output logic        o_req_valid,
  input  logic        i_req_ready,
  output logic        o_req_fail
);
  localparam int IW = $clog2(P_DEPTH);
  localparam int AW = $clog2(P_TIMEOUT_TICKS + 1);
  localparam int TW = $clog2(P_RETRY_TICKS + 1);
  localparam int RW = $clog2(P_MAX_RETRY + 2);

  logic [P_DEPTH-1:0]         ent_vld, ent_we;
  logic [P_DEPTH-1:0][31:0]   ent_ip;
  logic [P_DEPTH-1:0][47:0]   ent_mac;
  logic [P_DEPTH-1:0][AW-1:0] ent_age;

  // Victim select: same-IP entry, else lowest free slot, else oldest (lowest index on tie).
  logic          m_any, f_any;
  logic [IW-1:0] m_idx, f_idx, o_idx, vict_idx;
  logic [AW-1:0] o_age_max;

  always_comb begin
    m_any = 1'b0; m_idx = '0;
    f_any = 1'b0; f_idx = '0;
    o_idx = '0;   o_age_max = ent_age[0];
    for (int i = 0; i < P_DEPTH; i++) begin
      if (!m_any && ent_vld[i] && ent_ip[i] == i_updata_ip) begin
        m_any = 1'b1; m_idx = IW'(i);
      end
      if (!f_any && !ent_vld[i]) begin
        f_any = 1'b1; f_idx = IW'(i);
      end
      if (ent_age[i] > o_age_max) begin
        o_age_max = ent_age[i]; o_idx = IW'(i);
      end
    end
    vict_idx = m_any ? m_idx : (f_any ? f_idx : o_idx);
  end

  for (genvar g = 0; g < P_DEPTH; g++) begin : g_ent
    assign ent_we[g] = i_updata_valid && (vict_idx == IW'(g));
    arp_cache_entry #(.P_TIMEOUT_TICKS(P_TIMEOUT_TICKS), .AW(AW)) u_ent (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_tick(i_tick),
      .i_we(ent_we[g]), .i_ip(i_updata_ip), .i_mac(i_updata_mac),
      .o_vld(ent_vld[g]), .o_ip(ent_ip[g]), .o_mac(ent_mac[g]), .o_age(ent_age[g])
    );
  end

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} s_state_t;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_WAIT} r_state_t;

  s_state_t      s_state;
  r_state_t      r_state;
  logic [IW-1:0] scan_idx;
  logic [31:0]   seek_ip_q;
  logic [TW-1:0] tick_cnt;
  logic [RW-1:0] retry_cnt;
  logic          scan_hit, scan_last, miss_fire, upd_match;

  // 0.0.0.0 never matches, so it always misses and never raises a request.
  assign scan_hit  = (s_state == S_SCAN) && ent_vld[scan_idx] &&
                     (ent_ip[scan_idx] == seek_ip_q) && (seek_ip_q != '0);
  assign scan_last = (scan_idx == IW'(P_DEPTH - 1));
  assign miss_fire = (s_state == S_SCAN) && !scan_hit && scan_last && (seek_ip_q != '0);
  assign upd_match = i_updata_valid && (i_updata_ip == o_req_ip);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_state      <= S_IDLE;
      o_seek_ready <= 1'b1;
      o_seek_done  <= 1'b0;
      o_seek_hit   <= 1'b0;
      o_seek_mac   <= '0;
      scan_idx     <= '0;
      seek_ip_q    <= '0;
    end else begin
      o_seek_done <= 1'b0;
      case (s_state)
        S_IDLE: if (i_seek_valid) begin
          seek_ip_q    <= i_seek_ip;
          scan_idx     <= '0;
          o_seek_ready <= 1'b0;
          s_state      <= S_SCAN;
        end
        S_SCAN: begin
          if (scan_hit) begin
            o_seek_done <= 1'b1;
            o_seek_hit  <= 1'b1;
            o_seek_mac  <= ent_mac[scan_idx];
            s_state     <= S_DONE;
          end else if (scan_last) begin
            o_seek_done <= 1'b1;
            o_seek_hit  <= 1'b0;
            o_seek_mac  <= '0;
            s_state     <= S_DONE;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        S_DONE: begin
          o_seek_hit   <= 1'b0;
          o_seek_mac   <= '0;
          o_seek_ready <= 1'b1;
          s_state      <= S_IDLE;
        end
        default: begin
          o_seek_ready <= 1'b1;
          s_state      <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= R_IDLE;
      o_req_ip    <= '0;
      o_req_valid <= 1'b0;
      o_req_fail  <= 1'b0;
      tick_cnt    <= '0;
      retry_cnt   <= '0;
    end else begin
      o_req_fail <= 1'b0;
      if (i_flush) begin
        r_state     <= R_IDLE;
        o_req_valid <= 1'b0;
      end else begin
        case (r_state)
          R_IDLE: if (miss_fire) begin
            o_req_ip    <= seek_ip_q;
            o_req_valid <= 1'b1;
            retry_cnt   <= '0;
            r_state     <= R_SEND;
          end
          R_SEND: begin
            if (upd_match) begin
              o_req_valid <= 1'b0;
              r_state     <= R_IDLE;
            end else if (i_req_ready) begin
              o_req_valid <= 1'b0;
              tick_cnt    <= '0;
              r_state     <= R_WAIT;
            end
          end
          R_WAIT: begin
            if (upd_match) begin
              r_state <= R_IDLE;
            end else if (i_tick) begin
              if (tick_cnt == TW'(P_RETRY_TICKS - 1)) begin
                tick_cnt <= '0;
                if (retry_cnt < RW'(P_MAX_RETRY)) begin
                  retry_cnt   <= retry_cnt + 1'b1;
                  o_req_valid <= 1'b1;
                  r_state     <= R_SEND;
                end else begin
                  o_req_fail <= 1'b1;
                  r_state    <= R_IDLE;
                end
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
          default: r_state <= R_IDLE;
        endcase
      end
    end
  end
endmodule
